// File: rtl/n4_b10_downcounter.sv
// Four-digit BCD down-counter with synchronous clamped load and ripple borrow-out.
// Define N4_B10_DOWNCOUNTER_SATURATE_EN to make it hold at 0000 instead of wrapping to 9999.

module n4_b10_digit (
  input  logic       m_clock,
  input  logic       m_reset_,
  input  logic       load,
  input  logic       en,
  input  logic       hold,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] d_clamped;
  logic [3:0] q_dec;

  assign d_clamped = (d > 4'd9) ? 4'd9 : d;
  assign q_dec     = (q == 4'd0) ? 4'd9 : q - 4'd1;

  // Borrow is taken from the enable even when hold blocks the step, so eu keeps pulsing at zero
  assign borrow = en & (q == 4'd0);

  always_ff @(posedge m_clock or negedge m_reset_) begin
    if (!m_reset_) begin
      q <= 4'd0;
    end else if (load) begin
      q <= d_clamped;
    end else if (en && !hold) begin
      q <= q_dec;
    end
  end

endmodule

module n4_b10_downcounter (
  input  logic       m_clock,
  input  logic       m_reset_,
  input  logic       m_ei,
  input  logic       m_load,
  input  logic [3:0] d03_d00,
  input  logic [3:0] d13_d10,
  input  logic [3:0] d23_d20,
  input  logic [3:0] d33_d30,
  output logic       eu,
  output logic       zero,
  output logic [3:0] q03_q00,
  output logic [3:0] q13_q10,
  output logic [3:0] q23_q20,
  output logic [3:0] q33_q30
);

  logic [3:0] d_digit [4];
  logic [3:0] q_digit [4];
  logic [4:0] chain;
  logic       hold;

  assign d_digit[0] = d03_d00;
  assign d_digit[1] = d13_d10;
  assign d_digit[2] = d23_d20;
  assign d_digit[3] = d33_d30;

  assign q03_q00 = q_digit[0];
  assign q13_q10 = q_digit[1];
  assign q23_q20 = q_digit[2];
  assign q33_q30 = q_digit[3];

  assign zero     = (q_digit[0] == 4'd0) && (q_digit[1] == 4'd0) &&
                    (q_digit[2] == 4'd0) && (q_digit[3] == 4'd0);
  assign chain[0] = m_ei & ~m_load;
  assign eu       = chain[4];

`ifdef N4_B10_DOWNCOUNTER_SATURATE_EN
  assign hold = zero;
`else
  assign hold = 1'b0;
`endif

  // Each digit's enable is the borrow of the digit below it
  for (genvar k = 0; k < 4; k++) begin : g_digit
    n4_b10_digit u_digit (
      .m_clock  (m_clock),
      .m_reset_ (m_reset_),
      .load     (m_load),
      .en       (chain[k]),
      .hold     (hold),
      .d        (d_digit[k]),
      .q        (q_digit[k]),
      .borrow   (chain[k+1])
    );
  end

endmodule
